// File: rtl/lab2_3_sweep_checker_pkg.sv
// Shared constants and state type for the lab2_3 function block and its sweep checker.
package lab2_3_sweep_checker_pkg;

  // Golden truth table: bit i is the required z for x == i.
  localparam logic [7:0] LAB2_3_TRUTH_TABLE = 8'b00111001;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 2;
  localparam logic [2:0]  LAST_INDEX            = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/lab2_3_sweep_checker_if.sv
// Stimulus/response and status signals between the sweep checker and its harness.
interface lab2_3_sweep_checker_if;
  logic       start;
  logic [2:0] x_out;
  logic       z_in;
  logic       error_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] captured;
  logic [3:0] err_count;

  modport master (
    input  start, z_in, error_in,
    output x_out, busy, done, pass, captured, err_count
  );

  modport slave (
    output start, z_in, error_in,
    input  x_out, busy, done, pass, captured, err_count
  );
endinterface

// File: rtl/lab2_3_sweep_checker.sv
// Sweeps x through 0..7, samples z/error after a settle interval and scores the
// captured truth table against EXPECTED.
module lab2_3_sweep_checker
  import lab2_3_sweep_checker_pkg::*;
#(
  parameter logic [7:0]  EXPECTED      = LAB2_3_TRUTH_TABLE,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  lab2_3_sweep_checker_if.master sw
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  sweep_state_t state_q, state_n;
  logic [2:0]   x_q, x_n;
  logic [2:0]   idx_q, idx_n;
  logic [3:0]   cnt_q, cnt_n;
  logic [3:0]   err_q, err_n;
  logic [7:0]   cap_q, cap_n;
  logic         busy_q, busy_n;
  logic         done_q, done_n;
  logic         pass_q, pass_n;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      cap_q   <= cap_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
    end
  end

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    cap_n   = cap_q;
    busy_n  = busy_q;
    done_n  = done_q;
    pass_n  = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (sw.start) begin
          cap_n   = '0;
          err_n   = '0;
          idx_n   = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = DRIVE;
        end
      end

      DRIVE: begin
        x_n     = idx_q;
        cnt_n   = SETTLE_LOAD;
        state_n = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end

      SETTLE: begin
        cnt_n = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_n = SAMPLE;
      end

      SAMPLE: begin
        cap_n[idx_q] = sw.z_in;
        // Pass path is the if-branch so an X/Z on z_in falls into the count.
        if ((sw.z_in == EXPECTED[idx_q]) && !sw.error_in) err_n = err_q;
        else                                              err_n = err_q + 4'd1;
        if (idx_q == LAST_INDEX) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == 4'd0);
          state_n = DONE;
        end else begin
          idx_n   = idx_q + 3'd1;
          state_n = DRIVE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign sw.x_out     = x_q;
  assign sw.busy      = busy_q;
  assign sw.done      = done_q;
  assign sw.pass      = pass_q;
  assign sw.captured  = cap_q;
  assign sw.err_count = err_q;

endmodule

// File: tb/tb_lab2_3_sweep_checker.sv
// Randomized self-checking bench: two checkers (settle 2 and settle 0) driving a
// behavioural function block with injectable z flips, stuck-at-0 and error flags.
module tb_lab2_3_sweep_checker;
  import lab2_3_sweep_checker_pkg::*;

  localparam logic [7:0] GOLDEN = 8'h39;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  lab2_3_sweep_checker_if ifa ();
  lab2_3_sweep_checker_if ifb ();

  lab2_3_sweep_checker #(.SETTLE_CYCLES(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .sw(ifa.master));
  lab2_3_sweep_checker #(.SETTLE_CYCLES(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .sw(ifb.master));

  // Function block model with fault injection.
  logic [7:0] tt;
  logic [7:0] flip;
  logic [7:0] errmask;
  logic       stuck0;

  always_comb begin
    ifa.z_in     = stuck0 ? 1'b0 : (tt[ifa.x_out] ^ flip[ifa.x_out]);
    ifa.error_in = errmask[ifa.x_out];
    ifb.z_in     = stuck0 ? 1'b0 : (tt[ifb.x_out] ^ flip[ifb.x_out]);
    ifb.error_in = errmask[ifb.x_out];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int xhist[8];

  function automatic logic       cur_done(input bit sel); return sel ? ifb.done : ifa.done; endfunction
  function automatic logic       cur_busy(input bit sel); return sel ? ifb.busy : ifa.busy; endfunction
  function automatic logic       cur_pass(input bit sel); return sel ? ifb.pass : ifa.pass; endfunction
  function automatic logic [2:0] cur_x(input bit sel);    return sel ? ifb.x_out : ifa.x_out; endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) ifb.start = v; else ifa.start = v;
  endtask

  // Reference: each vector's captured bit is whatever the block drives; a vector
  // fails if that differs from the golden table or its error flag is raised.
  task automatic ref_model(output logic [7:0] c, output int e, output logic p);
    e = 0;
    for (int v = 0; v < 8; v++) begin
      c[v] = stuck0 ? 1'b0 : (tt[v] ^ flip[v]);
      if (c[v] != GOLDEN[v] || errmask[v]) e = e + 1;
    end
    p = (e == 0);
  endtask

  task automatic run_sweep(input bit sel, input int extra_at, output int cycles);
    int per_vec;
    bit hist_ok;
    per_vec = sel ? 2 : 4;
    for (int v = 0; v < 8; v++) xhist[v] = 0;
    @(negedge clock);
    set_start(sel, 1'b1);
    @(posedge clock); #1;
    set_start(sel, 1'b0);
    n_checks++;
    if (cur_busy(sel) !== 1'b1 || cur_done(sel) !== 1'b0 || cur_pass(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL accept[%0d]: busy/done/pass=%b%b%b required 100", sel,
               cur_busy(sel), cur_done(sel), cur_pass(sel));
    end
    cycles = 0;
    while (cur_done(sel) !== 1'b1 && cycles < 400) begin
      set_start(sel, (cycles == extra_at) ? 1'b1 : 1'b0);
      @(posedge clock); #1;
      cycles++;
      xhist[cur_x(sel)]++;
    end
    set_start(sel, 1'b0);
    n_checks++;
    if (cycles != 8 * per_vec) begin
      n_fail++;
      $display("FAIL done_latency[%0d]: %0d cycles required %0d", sel, cycles, 8 * per_vec);
    end
    hist_ok = 1'b1;
    for (int v = 0; v < 8; v++) if (xhist[v] != per_vec) hist_ok = 1'b0;
    n_checks++;
    if (!hist_ok) begin
      n_fail++;
      $display("FAIL x_sequence[%0d]: x0..7 held %0d %0d %0d %0d %0d %0d %0d %0d required %0d each",
               sel, xhist[0], xhist[1], xhist[2], xhist[3], xhist[4], xhist[5], xhist[6], xhist[7], per_vec);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (ifa.x_out !== 3'd0 || ifa.captured !== 8'd0 || ifa.err_count !== 4'd0 ||
        ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: x=%h cap=%h err=%h b/d/p=%b%b%b required all zero",
               ifa.x_out, ifa.captured, ifa.err_count, ifa.busy, ifa.done, ifa.pass);
    end
    n_checks++;
    if (ifb.x_out !== 3'd0 || ifb.captured !== 8'd0 || ifb.err_count !== 4'd0 ||
        ifb.busy !== 1'b0 || ifb.done !== 1'b0 || ifb.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: x=%h cap=%h err=%h b/d/p=%b%b%b required all zero",
               ifb.x_out, ifb.captured, ifb.err_count, ifb.busy, ifb.done, ifb.pass);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_nominal();
    int cyc;
    stuck0 = 1'b0; flip = '0; errmask = '0;
    run_sweep(1'b0, -1, cyc);
    n_checks++;
    if (ifa.captured !== 8'h39 || ifa.err_count !== 4'd0 || ifa.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal: cap=%h err=%0d pass=%b required cap=39 err=0 pass=1",
               ifa.captured, ifa.err_count, ifa.pass);
    end
  endtask

  task automatic test_stuck_at();
    int cyc;
    stuck0 = 1'b1; flip = '0; errmask = '0;
    run_sweep(1'b0, -1, cyc);
    n_checks++;
    if (ifa.captured !== 8'h00 || ifa.err_count !== 4'd4 || ifa.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_at0: cap=%h err=%0d pass=%b required cap=00 err=4 pass=0",
               ifa.captured, ifa.err_count, ifa.pass);
    end
    stuck0 = 1'b0;
  endtask

  task automatic test_error_flag();
    int cyc;
    stuck0 = 1'b0; flip = '0; errmask = 8'b0010_0000;
    run_sweep(1'b0, -1, cyc);
    n_checks++;
    if (ifa.captured !== 8'h39 || ifa.err_count !== 4'd1 || ifa.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL error_flag: cap=%h err=%0d pass=%b required cap=39 err=1 pass=0",
               ifa.captured, ifa.err_count, ifa.pass);
    end
    errmask = '0;
  endtask

  task automatic test_random();
    int         cyc, e;
    logic [7:0] c;
    logic       p;
    for (int it = 0; it < 6; it++) begin
      stuck0  = 1'b0;
      flip    = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      errmask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      ref_model(c, e, p);
      run_sweep(1'b0, -1, cyc);
      n_checks++;
      if (ifa.captured !== c || ifa.err_count !== 4'(e) || ifa.pass !== p) begin
        n_fail++;
        $display("FAIL random[%0d] flip=%h em=%h: cap=%h err=%0d pass=%b required cap=%h err=%0d pass=%b",
                 it, flip, errmask, ifa.captured, ifa.err_count, ifa.pass, c, e, p);
      end
    end
    flip = '0; errmask = '0;
  endtask

  task automatic test_start_while_busy();
    int cyc;
    stuck0 = 1'b0; flip = '0; errmask = '0;
    run_sweep(1'b0, 10, cyc);
    n_checks++;
    if (ifa.captured !== 8'h39 || ifa.err_count !== 4'd0 || ifa.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: cap=%h err=%0d pass=%b required cap=39 err=0 pass=1",
               ifa.captured, ifa.err_count, ifa.pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    int guard;
    stuck0 = 1'b0; flip = '0; errmask = '0;
    @(negedge clock);
    ifa.start = 1'b1;
    @(posedge clock); #1;
    ifa.start = 1'b0;
    guard = 0;
    while (ifa.x_out !== 3'd3 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL reach_x3: x=%h after %0d cycles required 3", ifa.x_out, guard);
    end
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (dut_a.state_q !== IDLE || ifa.x_out !== 3'd0 || ifa.captured !== 8'd0 ||
        ifa.err_count !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: st=%0d x=%h cap=%h err=%0d busy=%b done=%b required IDLE and zeros",
               dut_a.state_q, ifa.x_out, ifa.captured, ifa.err_count, ifa.busy, ifa.done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_sweep(1'b0, -1, cyc);
    n_checks++;
    if (ifa.captured !== 8'h39 || ifa.err_count !== 4'd0 || ifa.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: cap=%h err=%0d pass=%b required cap=39 err=0 pass=1",
               ifa.captured, ifa.err_count, ifa.pass);
    end
  endtask

  task automatic test_settle0_restart();
    int         cyc, e;
    logic [7:0] c;
    logic       p;
    stuck0 = 1'b0; flip = '0; errmask = '0;
    run_sweep(1'b1, -1, cyc);
    n_checks++;
    if (ifb.captured !== 8'h39 || ifb.err_count !== 4'd0 || ifb.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL settle0: cap=%h err=%0d pass=%b required cap=39 err=0 pass=1",
               ifb.captured, ifb.err_count, ifb.pass);
    end
    flip    = 8'($urandom_range(1, 255));
    errmask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
    ref_model(c, e, p);
    run_sweep(1'b1, -1, cyc);
    n_checks++;
    if (ifb.captured !== c || ifb.err_count !== 4'(e) || ifb.pass !== p) begin
      n_fail++;
      $display("FAIL settle0_restart flip=%h em=%h: cap=%h err=%0d pass=%b required cap=%h err=%0d pass=%b",
               flip, errmask, ifb.captured, ifb.err_count, ifb.pass, c, e, p);
    end
  endtask

  initial begin
    tt      = LAB2_3_TRUTH_TABLE;
    flip    = '0;
    errmask = '0;
    stuck0  = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    test_nominal();
    test_stuck_at();
    test_error_flag();
    test_random();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_settle0_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_3_sweep_checker.md
Name: lab2_3_sweep_checker

Overview:
- Upstream/downstream harness stage for the 3-input boolean function block.
- Drives its 3-bit input `x` through all 8 codes in ascending order.
- Waits a settle interval, then samples the block's `z` and `error` outputs.
- Builds the captured truth table, counts mismatches against the expected table, and reports pass/fail, so the function block can be self-checked in hardware or simulation.

Parameters:
- EXPECTED, 8'b00111001, golden truth table; bit `i` is the required `z` for `x == i`.
- SETTLE_CYCLES, 2, wait cycles between driving `x_out` and sampling `z_in`/`error_in`; legal range 0..15.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- x_out  output  3  registered stimulus to the function block's `x` input.
- z_in  input  1  function block's `z` output.
- error_in  input  1  function block's `error` output.
- busy  output  1  high while a sweep is in progress (DRIVE, SETTLE, SAMPLE).
- done  output  1  high in DONE; holds until the next accepted start or reset.
- pass  output  1  valid when `done` is high; 1 iff `err_count == 0`.
- captured  output  8  bit `i` = `z_in` sampled while `x_out == i`.
- err_count  output  4  number of vectors that failed, range 0..8.

Behaviour:
- Reset (`reset_n == 0` at a clock edge), from any state including mid-sweep:
  - state = IDLE;
  - `x_out`, `captured`, `err_count`, the vector index and the settle counter = 0;
  - `busy`, `done`, `pass` = 0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE or DONE with `start == 1`:
  - clear `captured`, `err_count`, index, `done`, `pass`;
  - `busy` = 1; next state DRIVE.
- DRIVE (1 cycle):
  - `x_out` <= index; settle counter <= SETTLE_CYCLES;
  - next state SETTLE, or SAMPLE directly if SETTLE_CYCLES == 0.
- SETTLE:
  - decrement the counter each cycle;
  - go to SAMPLE on the cycle the counter reaches 1, so exactly SETTLE_CYCLES cycles are spent in SETTLE;
  - `x_out` is held stable.
- SAMPLE (1 cycle):
  - `captured[index]` <= `z_in`;
  - fail = (`z_in != EXPECTED[index]`) OR `error_in`; if fail, `err_count` <= `err_count + 1`;
  - if index == 7: next state DONE, else index <= index + 1 and next state DRIVE;
  - `x_out` is still held during SAMPLE.
- DONE:
  - `busy` = 0, `done` = 1, `pass` = (final `err_count == 0`), registered on DONE entry;
  - `x_out` keeps its last value (7);
  - results hold until the next start or reset.
- Timing: each vector takes 2 + SETTLE_CYCLES cycles. With the default SETTLE_CYCLES, `done` rises 32 clocks after the start-accept edge.
- `start` while `busy` is ignored; the sweep is not restarted and results are not cleared.
- `err_count` cannot exceed 8 (one increment per vector); 4 bits suffice and no wrap is possible.
- Index is 3 bits; the terminal check uses index == 7 before increment, so there is no wrap to 0 inside a sweep.
- `error_in` counts as a failure even if `z_in` matches EXPECTED.
- A failing vector increments `err_count` once, regardless of whether one or both failure conditions are true.
- `z_in` of X or Z is treated as a mismatch in simulation.

Decomposition:
- Shared package holds:
  - LAB2_3_TRUTH_TABLE = 8'b00111001, also used by the function block;
  - state encoding localparams (IDLE = 0, DRIVE = 1, SETTLE = 2, SAMPLE = 3, DONE = 4; 3-bit);
  - SETTLE_CYCLES default.
- No sub-module is natural; the settle counter is a few lines inline. The bench instantiates lab2_3_sweep_checker alongside the function block.

Test Plan:
- Nominal: real function block connected, start pulse → `x_out` steps 0..7; `done` = 1 at cycle 32; `captured` = 8'h39; `err_count` = 0; `pass` = 1.
- Stuck-at fault: `z_in` tied to 0 → `captured` = 8'h00; `err_count` = 4; `pass` = 0.
- Error flag injection: `z_in` correct but `error_in` forced 1 only while `x_out` == 5 → `captured` = 8'h39; `err_count` = 1; `pass` = 0.
- Start while busy: second start pulse at cycle 10 → ignored; `done` still at cycle 32; results as in nominal.
- Reset mid-sweep: `reset_n` low for one edge while `x_out` == 3 → next cycle: state IDLE, `x_out` = 0, `captured` = 0, `err_count` = 0, `busy` = 0; a fresh start then completes nominally.
- SETTLE_CYCLES = 0, restart from DONE: start → `done` at cycle 16, `captured` = 8'h39; a second start from DONE clears `done`/`pass` on the accept edge and repeats.
